// File: rtl/or1k_tile_arb_pkg.sv
// Shared types and helpers for the tile Wishbone arbiter and its round-robin picker.
package or1k_tile_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        TOERR = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Index widths never collapse to zero bits, even for a single master.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/or1k_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_id, wrapping at N.
module or1k_rr_pick
    import or1k_tile_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_id,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] id,
    output logic          valid
);

    localparam int DN = 2 * N;

    logic [DN-1:0] dbl;
    logic [DN-1:0] masked;

    // Doubling the request vector turns the wrap-around search into a plain
    // lowest-set-bit search above last_id.
    always_comb begin
        dbl    = {req, req};
        masked = dbl & ~((DN'(2) << last_id) - DN'(1));
        id     = '0;
        onehot = '0;
        valid  = |req;
        for (int j = DN - 1; j >= 0; j--) begin
            if (masked[j]) begin
                id = (j >= N) ? IW'(j - N) : IW'(j);
            end
        end
        if (valid) begin
            onehot[id] = 1'b1;
        end
    end

endmodule

// File: rtl/or1k_tile_wb_arbiter.sv
// Round-robin Wishbone B3 classic arbiter sharing one tile slave port between N masters,
// with a watchdog that terminates stalled accesses with err.
module or1k_tile_wb_arbiter
    import or1k_tile_arb_pkg::*;
#(
    parameter int  N       = 8,
    parameter int  AW      = 32,
    parameter int  DW      = 32,
    parameter int  TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IW      = clog2_min1(N),
    localparam int SW      = DW / 8
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N*SW-1:0] m_sel_i,
    input  logic [N*AW-1:0] m_adr_i,
    input  logic [N*DW-1:0] m_dat_i,
    output logic [DW-1:0]   m_dat_o,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [SW-1:0]   s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [N-1:0]    grant_o,
    output logic [IW-1:0]   grant_id_o,
    output arb_state_t      dbg_state
);

    localparam int            CW      = clog2_min1(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    arb_state_t    state;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] last_id;
    logic [CW-1:0] stall_cnt;

    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_id;
    logic          pick_valid;

    logic          g_cyc, g_stb, g_we;
    logic [SW-1:0] g_sel;
    logic [AW-1:0] g_adr;
    logic [DW-1:0] g_dat;
    logic          busy, stalled;

    or1k_rr_pick #(.N(N), .IW(IW)) u_pick (
        .req     (m_cyc_i),
        .last_id (last_id),
        .onehot  (pick_onehot),
        .id      (pick_id),
        .valid   (pick_valid)
    );

    // AND-OR mux keyed by the one-hot grant; an empty grant yields all zeros.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) begin
                g_cyc = g_cyc | m_cyc_i[k];
                g_stb = g_stb | m_stb_i[k];
                g_we  = g_we  | m_we_i[k];
                g_sel = g_sel | m_sel_i[k*SW +: SW];
                g_adr = g_adr | m_adr_i[k*AW +: AW];
                g_dat = g_dat | m_dat_i[k*DW +: DW];
            end
        end
    end

    assign busy    = (state == BUSY);
    assign s_cyc_o = busy & g_cyc;
    assign s_stb_o = busy & g_cyc & g_stb;
    assign s_we_o  = busy & g_we;
    assign s_sel_o = busy ? g_sel : '0;
    assign s_adr_o = busy ? g_adr : '0;
    assign s_dat_o = busy ? g_dat : '0;
    assign m_dat_o = s_dat_i;

    // Slave responses only reach the owner while BUSY, so late acks after release vanish.
    assign m_ack_o = {N{busy & s_ack_i}} & grant;
    assign m_err_o = {N{(busy & s_err_i) | (state == TOERR)}} & grant;

    assign stalled    = s_stb_o & ~s_ack_i & ~s_err_i & (TIMEOUT != 0);
    assign grant_o    = grant;
    assign grant_id_o = grant_id;
    assign dbg_state  = state;

    // wb_rst_i is active-low despite its historical name.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            last_id   <= IW'(N - 1);
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (pick_valid) begin
                        grant    <= pick_onehot;
                        grant_id <= pick_id;
                        last_id  <= pick_id;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        state     <= IDLE;
                        grant     <= '0;
                        grant_id  <= '0;
                        stall_cnt <= '0;
                    end else if (stalled) begin
                        if (stall_cnt == TO_LAST) begin
                            state     <= TOERR;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + CW'(1);
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    grant    <= '0;
                    grant_id <= '0;
                end
            endcase
        end
    end

endmodule
